// File: rtl/aes256_key_expand_pkg.sv
// rtl/aes256_key_expand_pkg.sv - AES-256 key schedule constants, S-box and Rcon helpers
package aes256_key_expand_pkg;

  localparam int NK        = 8;
  localparam int NR        = 14;
  localparam int NUM_WORDS = 4 * (NR + 1);

  typedef logic [31:0] word_t;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at bit offset 8*(255-b); ~b is 255-b.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  // Round constant for schedule word 8*i; AES-256 only uses i = 1..7.
  function automatic logic [7:0] rcon(input logic [2:0] i);
    logic [7:0] r;
    case (i)
      3'd1:    r = 8'h01;
      3'd2:    r = 8'h02;
      3'd3:    r = 8'h04;
      3'd4:    r = 8'h08;
      3'd5:    r = 8'h10;
      3'd6:    r = 8'h20;
      3'd7:    r = 8'h40;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes256_key_expand_subword.sv
// rtl/aes256_key_expand_subword.sv - combinational SubWord: four parallel S-box lookups
module aes256_key_expand_subword
  import aes256_key_expand_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  assign word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                     sbox(word_in[15:8]),  sbox(word_in[7:0])};

endmodule

// File: rtl/aes256_key_expand.sv
// rtl/aes256_key_expand.sv - AES-256 key expansion, one word per cycle, registered round-key read port
module aes256_key_expand
  import aes256_key_expand_pkg::*;
(
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [255:0] key_in,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_out,
  output logic         keys_done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [5:0] CNT_FIRST = 6'(NK);
  localparam logic [5:0] CNT_LAST  = 6'(NUM_WORDS - 1);
  localparam logic [3:0] RK_LAST   = 4'(NR);

  logic [1:0]   state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [127:0] rk_out_q, rk_out_d;
  word_t        w_q [NUM_WORDS];

  logic  accept;
  logic  wr_en;
  word_t prev_word;
  word_t sub_in;
  word_t sub_out;
  word_t temp;
  word_t new_word;

  assign key_ready = (state_q != ST_EXPAND);
  assign keys_done = (state_q == ST_DONE);
  assign rk_out    = rk_out_q;
  // Reset takes priority over a key presented in the same cycle.
  assign accept    = key_valid & key_ready & ~sys_rst;
  assign wr_en     = (state_q == ST_EXPAND);

  assign prev_word = w_q[cnt_q - 6'd1];
  assign sub_in    = (cnt_q[2:0] == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  aes256_key_expand_subword u_subword (
    .word_in  (sub_in),
    .word_out (sub_out)
  );

  // Schedule recurrence: w[cnt] = w[cnt-8] ^ transformed w[cnt-1].
  always_comb begin
    temp = prev_word;
    if (cnt_q[2:0] == 3'd0) begin
      temp = sub_out ^ {rcon(cnt_q[5:3]), 24'h0};
    end else if (cnt_q[2:0] == 3'd4) begin
      temp = sub_out;
    end
    new_word = w_q[cnt_q - 6'd8] ^ temp;
  end

  // FSM and word counter; IDLE and DONE both accept a new key.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_EXPAND: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        if (accept) begin
          state_d = ST_EXPAND;
          cnt_d   = CNT_FIRST;
        end
      end
    endcase
  end

  // Round-key read mux; out-of-range indices read as zero.
  always_comb begin
    rk_out_d = '0;
    if (rk_addr <= RK_LAST) begin
      rk_out_d = {w_q[{rk_addr, 2'b00}], w_q[{rk_addr, 2'b01}],
                  w_q[{rk_addr, 2'b10}], w_q[{rk_addr, 2'b11}]};
    end
  end

  // Control state and read register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rk_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rk_out_q <= rk_out_d;
    end
  end

  // Word storage: key words on acceptance, one schedule word per EXPAND cycle.
  always_ff @(posedge sys_clk) begin
    if (accept) begin
      for (int i = 0; i < NK; i++) begin
        w_q[i] <= key_in[255 - 32*i -: 32];
      end
    end else if (wr_en) begin
      w_q[cnt_q] <= new_word;
    end
  end

endmodule

// File: tb/tb_aes256_key_expand.sv
// tb/tb_aes256_key_expand.sv - scoreboard bench for aes256_key_expand
module tb_aes256_key_expand;

  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] A3_RK0  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] A3_RK1  = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] A3_RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] A3_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;
  localparam logic [127:0] ZERO_RK2 = 128'h62636363626363636263636362636363;

  localparam int K_RK    = 0;
  localparam int K_DONE  = 1;
  localparam int K_READY = 2;

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic         key_valid;
  logic         key_ready;
  logic [255:0] key_in;
  logic [3:0]   rk_addr;
  logic [127:0] rk_out;
  logic         keys_done;

  always #5 sys_clk = ~sys_clk;

  aes256_key_expand dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .rk_addr   (rk_addr),
    .rk_out    (rk_out),
    .keys_done (keys_done)
  );

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  int           due_q  [$];
  int           kind_q [$];
  logic [127:0] exp_q  [$];
  string        name_q [$];

  logic [7:0]  sbox_tab [256];
  logic [31:0] mw [60];

  // ---------------- reference model (GF(2^8) arithmetic) ----------------
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] b;
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      b   = 8'(a);
      inv = 8'h00;
      if (b != 8'h00) begin
        for (int c = 1; c < 256; c++) begin
          if (gmul(b, 8'(c)) == 8'h01) inv = 8'(c);
        end
      end
      sbox_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] key);
    logic [7:0]  rc;
    logic [31:0] t;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) mw[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = mw[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-8] ^ t;
    end
  endtask

  function automatic logic [127:0] model_rk(input int k);
    if (k > 14) return 128'h0;
    return {mw[4*k], mw[4*k+1], mw[4*k+2], mw[4*k+3]};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  function automatic void push(input int due, input int kind, input logic [127:0] exp, input string nm);
    due_q.push_back(due);
    kind_q.push_back(kind);
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endfunction

  logic [127:0] mon_act;
  always @(negedge sys_clk) begin
    for (int i = due_q.size() - 1; i >= 0; i--) begin
      if (due_q[i] == cyc) begin
        case (kind_q[i])
          K_RK:    mon_act = rk_out;
          K_DONE:  mon_act = {127'b0, keys_done};
          default: mon_act = {127'b0, key_ready};
        endcase
        n_vec++;
        if (mon_act !== exp_q[i]) begin
          n_err++;
          $display("FAIL %s: got %h expected %h (cycle %0d)", name_q[i], mon_act, exp_q[i], cyc);
        end
        due_q.delete(i);
        kind_q.delete(i);
        exp_q.delete(i);
        name_q.delete(i);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic read_rk(input int a, input logic [127:0] exp, input string nm);
    rk_addr = 4'(a);
    push(cyc + 1, K_RK, exp, nm);
    tick();
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 16; k++) read_rk(k, model_rk(k), $sformatf("%s_rk%0d", tag, k));
  endtask

  task automatic load_key(input logic [255:0] key, input bit chk_lat, input string tag);
    int c;
    c = cyc;
    model_expand(key);
    key_in    = key;
    key_valid = 1'b1;
    push(c,     K_READY, 128'd1, {tag, "_ready_pre"});
    push(c + 1, K_READY, 128'd0, {tag, "_ready_low"});
    push(c + 1, K_DONE,  128'd0, {tag, "_done_clr"});
    if (chk_lat) begin
      push(c + 52, K_DONE,  128'd0, {tag, "_done_early"});
      push(c + 53, K_DONE,  128'd1, {tag, "_done_rise"});
      push(c + 53, K_READY, 128'd1, {tag, "_ready_back"});
    end
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (keys_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    n_vec++;
    if (keys_done !== 1'b1) begin
      n_err++;
      $display("FAIL %s_done_timeout: keys_done=%b expected 1", tag, keys_done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [255:0] k53;
    int c0;
    build_sbox();
    sys_rst   = 1'b1;
    key_valid = 1'b0;
    key_in    = '0;
    rk_addr   = '0;
    tick();
    tick();
    push(cyc, K_READY, 128'd1, "rst_ready");
    push(cyc, K_DONE,  128'd0, "rst_done");
    push(cyc, K_RK,    128'd0, "rst_rk_out");
    tick();
    sys_rst = 1'b0;
    tick();

    // FIPS-197 A.3 key with latency checks; RK0/RK1 right after acceptance.
    load_key(KEY_A3, 1'b1, "a3");
    read_rk(0, A3_RK0, "a3_early_rk0");
    read_rk(1, A3_RK1, "a3_early_rk1");
    wait_done("a3");
    read_rk(0,  A3_RK0,  "a3_vec_rk0");
    read_rk(1,  A3_RK1,  "a3_vec_rk1");
    read_rk(2,  A3_RK2,  "a3_vec_rk2");
    read_rk(14, A3_RK14, "a3_vec_rk14");
    check_all("a3");

    // Reset mid-EXPAND, with a key presented in the reset cycle.
    load_key(KEY_A3, 1'b0, "rstmid");
    repeat (19) tick();
    sys_rst   = 1'b1;
    key_valid = 1'b1;
    key_in    = rand256();
    tick();
    sys_rst   = 1'b0;
    key_valid = 1'b0;
    push(cyc, K_DONE,  128'd0, "rstmid_done");
    push(cyc, K_READY, 128'd1, "rstmid_ready");
    push(cyc, K_RK,    128'd0, "rstmid_rk_out");
    tick();
    load_key(KEY_A3, 1'b1, "reload");
    wait_done("reload");
    read_rk(2,  A3_RK2,  "reload_rk2");
    read_rk(14, A3_RK14, "reload_rk14");

    // Back-to-back: all-zero key then re-key in DONE.
    load_key('0, 1'b1, "zero");
    wait_done("zero");
    read_rk(2, ZERO_RK2, "zero_vec_rk2");
    check_all("zero");
    load_key(KEY_A3, 1'b1, "rekey");
    wait_done("rekey");
    read_rk(2,  A3_RK2,  "rekey_rk2");
    read_rk(14, A3_RK14, "rekey_rk14");
    check_all("rekey");

    // Random keys against the reference model.
    for (int r = 0; r < 3; r++) begin
      load_key(rand256(), 1'b1, $sformatf("rnd%0d", r));
      wait_done($sformatf("rnd%0d", r));
      check_all($sformatf("rnd%0d", r));
    end

    // key_valid held for 100 cycles: acceptances at offsets 0 and 53 only.
    c0 = cyc;
    k53 = '0;
    push(c0 + 1,   K_READY, 128'd0, "hold_ready_low");
    push(c0 + 53,  K_DONE,  128'd1, "hold_done1");
    push(c0 + 53,  K_READY, 128'd1, "hold_ready1");
    push(c0 + 54,  K_DONE,  128'd0, "hold_done_clr");
    push(c0 + 54,  K_READY, 128'd0, "hold_ready_low2");
    push(c0 + 105, K_DONE,  128'd0, "hold_done2_early");
    push(c0 + 106, K_DONE,  128'd1, "hold_done2");
    for (int i = 0; i < 100; i++) begin
      key_in    = rand256();
      key_valid = 1'b1;
      if (i == 53) k53 = key_in;
      tick();
    end
    key_valid = 1'b0;
    model_expand(k53);
    wait_done("hold");
    check_all("hold");
    read_rk(15, 128'h0, "addr15");

    repeat (3) tick();
    while (due_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: never sampled (due cycle %0d)", name_q[0], due_q[0]);
      void'(due_q.pop_front());
      void'(kind_q.pop_front());
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes256_key_expand.md
Name: aes256_key_expand

Overview:
- Upstream neighbour of the per-round encrypt stage. Expands one 256-bit AES key into the 15 AES-256 round keys, per FIPS-197 key expansion (Nk=8, Nr=14).
- Generates one 32-bit schedule word per cycle and holds all 60 words in a register file.
- Serves round key k on a registered read port. The round controller drives the read port and forwards the result to the round stage's round_key input.

Parameters:
- None. AES-256 is fixed. NK=8, NR=14 and NUM_WORDS=60 are localparams taken from the shared defs include.

Ports:
- sys_clk    input   1    system clock; all state updates on the rising edge
- sys_rst    input   1    synchronous, active-high reset
- key_valid  input   1    key_in is valid this cycle
- key_ready  output  1    block can accept a new key
- key_in     input   256  cipher key; bits [255:224] = w0 (first key byte in bits [255:248])
- rk_addr    input   4    round-key index, 0..14
- rk_out     output  128  round key rk_addr, 1-cycle latency; {w[4k], w[4k+1], w[4k+2], w[4k+3]}, with w[4k] in bits [127:96]
- keys_done  output  1    full schedule valid for the current key

Behaviour:
- Clock and reset: one clock, sys_clk. Reset sys_rst is synchronous and active-high.
- Reset values: state=IDLE, key_ready=1, keys_done=0, rk_out=0, word counter=0. The word storage is not reset.
- FSM states: IDLE, EXPAND, DONE.
  - IDLE: key_ready=1. On key_valid & key_ready: w[0..7] <= key_in words, cnt <= 8, go to EXPAND.
  - EXPAND: key_ready=0, key_valid ignored. Each cycle: write w[cnt], cnt++. After w[59] is written, go to DONE.
  - DONE: keys_done=1, key_ready=1. An accepted new key behaves as in IDLE and clears keys_done on the same edge.
- Word recurrence, with temp = w[cnt-1]:
  - cnt%8==0: temp = SubWord(RotWord(temp)) ^ {Rcon[cnt/8], 24'h0}.
  - cnt%8==4: temp = SubWord(temp).
  - Otherwise temp is unchanged.
  - In all cases w[cnt] = w[cnt-8] ^ temp.
- RotWord and Rcon:
  - RotWord({a,b,c,d}) = {b,c,d,a}.
  - Rcon[1..7] = 01,02,04,08,10,20,40.
- Latency:
  - Key accepted at edge E0.
  - w[8] is written at E1, w[59] at E52.
  - keys_done is visible after E52, i.e. 52 cycles after acceptance.
  - key_ready is high again in the same cycle keys_done rises.
- Read port:
  - rk_out <= RK[rk_addr] every cycle, independent of FSM state.
  - rk_addr > 14 returns 128'h0.
  - Reads during EXPAND return whatever the storage currently holds. The consumer must gate its reads on keys_done.
  - Round key 0 and round key 1 (w0..w7) are readable from the cycle after acceptance.
- Boundary cases:
  - key_valid held high continuously: exactly one key is accepted per schedule. A second key is accepted only in DONE.
  - sys_rst asserted mid-EXPAND: return to IDLE, keys_done=0, partial schedule abandoned. The next accepted key rebuilds the full schedule.
  - sys_rst and key_valid in the same cycle: reset wins and the key is not accepted.
  - Re-key in DONE: the old schedule is overwritten progressively. keys_done stays 0 until the new schedule completes.

Decomposition:
- aes_defs.vh (shared include): NK, NR, NUM_WORDS, and the RCON function/table.
- The same include holds the S-box table, shared with the SubBytes stage.
- Sub-module aes_subword: 32-bit combinational SubWord built from 4 S-box lookups. It is the only sub-module.

Test Plan:
- FIPS-197 A.3 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, then wait for keys_done:
  - rk_addr=0 -> 603deb1015ca71be2b73aef0857d7781
  - rk_addr=1 -> 1f352c073b6108d72d9810a30914dff4
  - rk_addr=2 -> 9ba354118e6925afa51a8b5f2067fcde
  - rk_addr=14 -> fe4890d1e6188d0b046df344706c631e
- Latency: pulse key_valid at cycle 0 -> key_ready=0 from cycle 1; keys_done rises exactly 52 cycles after acceptance; key_ready returns to 1 in the same cycle.
- Reset mid-EXPAND at cycle 20 -> keys_done=0, key_ready=1, rk_out=0 on the next cycle. Then load the A.3 key again -> RK2 and RK14 match the values above.
- Back-to-back keys: load the all-zero key, wait for keys_done, then load the A.3 key:
  - all-zero key -> rk_addr=2 returns 62636363626363636263636362636363
  - A.3 key -> keys_done drops on acceptance; the new schedule matches the A.3 vectors.
- key_valid held high for 100 cycles -> exactly two acceptances (cycles 0 and 53). rk_addr=15 -> rk_out=0.
